traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
//  Sensor-actuated phase sequencer for a two-road intersection: main road A and side road B.
//  Steps an 8-phase cycle, drives the lamp vectors for both roads and the per-road countdowns.
//  Main road rests in green until the side road calls. Green is extended while only its own road has traffic.
//  Sits inside traffic_light_top, between sensor inputs and lamp/display logic.
// PARAMETERS
//  TICK_DIV  50_000_000  clk_50M cycles per 1 s tick; sim uses 4
//  A_G_SEC   30          main green base duration in seconds; 1..255 (also for every *_SEC below)
//  B_G_SEC   20          side green base duration in seconds
//  L_SEC     10          left-turn green duration in seconds, both roads
//  Y_SEC     3           yellow duration in seconds
//  AR_SEC    2           all-red clearance duration in seconds
//  EXT_SEC   5           green extension / rest reload in seconds
//  MAX_EXT   4           maximum extensions per green phase
// PORTS
//  clk_50M              in   1  system clock, 50 MHz
//  reset_btn            in   1  synchronous reset, active-high
//  AS1, AS2             in   1  main-road vehicle sensors; a_dem = AS1|AS2
//  BS1, BS2             in   1  side-road vehicle sensors; b_dem = BS1|BS2
//  a_lamp               out  4  main lamps {G,GL,Y,R}, one-hot
//  b_lamp               out  4  side lamps {G,GL,Y,R}, one-hot
//  main_road_countdown  out  8  seconds left in the current A phase; 0 otherwise
//  side_road_countdown  out  8  seconds left in the current B phase; 0 otherwise
//  phase                out  3  current phase code, for display and debug
// BEHAVIOUR
//  One clock domain; reset_btn is synchronous, active-high.
//  Phases:
//   0 A_GREEN, 1 A_LEFT, 2 A_YELLOW, 3 ALL_RED1
//   4 B_GREEN, 5 B_LEFT, 6 B_YELLOW, 7 ALL_RED2
//  Reset state:
//   phase=7 (ALL_RED2), cnt=AR_SEC, ext_used=0, b_req=0, tick divider cleared.
//   a_lamp=b_lamp=4'b0001. Both countdowns 0.
//  Tick: 1-cycle pulse every TICK_DIV cycles; the first tick comes TICK_DIV cycles after reset release.
//  Phase counter cnt (8 b):
//   - loaded with the phase duration on entry to a phase.
//   - on a tick with cnt>1: cnt decrements.
//   - on a tick with cnt==1: end-of-phase decision is taken.
//   A phase therefore lasts exactly load*TICK_DIV cycles.
//  b_req: set in any cycle where b_dem=1; cleared on entry to B_GREEN.
//   Decisions use (b_req | b_dem), so a demand in the decision cycle itself counts.
//  End-of-phase decisions:
//   A_GREEN:
//    - no side request                    -> rest: cnt=EXT_SEC, ext_used unchanged
//    - a_dem && ext_used<MAX_EXT          -> extend: cnt=EXT_SEC, ext_used++
//    - else                               -> A_LEFT
//   B_GREEN:
//    - b_dem && !a_dem && ext_used<MAX_EXT -> extend: cnt=EXT_SEC, ext_used++
//    - else                                -> B_LEFT
//   All other phases advance unconditionally: 1->2->3->4, 5->6->7->0.
//   ext_used clears on entry to either green phase.
//  Lamps and countdowns are decoded combinationally from the phase/cnt registers and change on the same edge as the state.
//   - A phases 0/1/2: a_lamp = G/GL/Y; b_lamp = R.
//   - B phases 4/5/6: the mirror of the above.
//   - Phases 3/7: both R.
//   - main_road_countdown = cnt in phases 0-2; side_road_countdown = cnt in phases 4-6.
//  Never two non-red lamps across roads; a_lamp and b_lamp are always exactly one-hot.
//  Reset mid-operation: the next edge forces the reset state regardless of phase or tick.
//  Unknown phase code (3-bit space is fully used) is not reachable; the default branch goes to ALL_RED2.
// STRUCTURE
//  Shared include traffic_defs.vh holds:
//   - phase codes 0-7
//   - lamp bit indices LAMP_G=3, LAMP_GL=2, LAMP_Y=1, LAMP_R=0
//  Sub-module sec_tick_gen #(TICK_DIV): counter plus 1-cycle tick, cleared by reset_btn.
//  FSM, cnt, ext_used, b_req and the output decode live in this module.
// TESTING (TICK_DIV=4; 1 s = 4 cycles)
//  1 reset_btn=1 for 3 cycles:
//    phase=7, a_lamp=b_lamp=0001, countdowns 0.
//    8 cycles after release: phase=0, a_lamp=1000, main_road_countdown=30.
//  2 All sensors 0:
//    A rests green; main countdown runs 30..1, then 5..1 repeatedly.
//    b_lamp stays 0001 for 200 s.
//  3 BS1 pulse of 1 cycle at t=10 s in A_GREEN, AS=0:
//    at 30 s -> A_LEFT(10) -> A_YELLOW(3) -> ALL_RED1(2) -> B_GREEN.
//    In B_GREEN: side_road_countdown=20, b_req=0.
//  4 AS1=BS1=1 held:
//    A_GREEN lasts 30+4*5 = 50 s, then A_LEFT.
//    B_GREEN gets no extension (a_dem=1) and lasts 20 s.
//  5 BS2=1, AS=0 held in B_GREEN:
//    4 extensions, B_GREEN lasts 40 s, then B_LEFT with side countdown 10.
//  6 reset_btn pulse mid-B_GREEN:
//    next edge phase=7, both lamps 0001, countdowns 0.
//    First tick occurs 4 cycles after release.

Source files
------------

// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared definitions for the two-road traffic phase scheduler:
// phase codes, lamp bit positions and a lamp decode helper.
package traffic_phase_scheduler_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_LEFT   = 3'd1,
        A_YELLOW = 3'd2,
        ALL_RED1 = 3'd3,
        B_GREEN  = 3'd4,
        B_LEFT   = 3'd5,
        B_YELLOW = 3'd6,
        ALL_RED2 = 3'd7
    } phase_t;

    localparam int LAMP_G  = 3;
    localparam int LAMP_GL = 2;
    localparam int LAMP_Y  = 1;
    localparam int LAMP_R  = 0;

    localparam logic [3:0] LAMP_GREEN  = 4'b1000;
    localparam logic [3:0] LAMP_LEFT   = 4'b0100;
    localparam logic [3:0] LAMP_YELLOW = 4'b0010;
    localparam logic [3:0] LAMP_RED    = 4'b0001;

    // Both roads walk the same green/left/yellow sequence, so the low two
    // phase bits select the lamp; step 3 is the all-red clearance.
    function automatic logic [3:0] lamp_for_step(input logic [1:0] step);
        logic [3:0] lamp;
        case (step)
            2'd0:    lamp = LAMP_GREEN;
            2'd1:    lamp = LAMP_LEFT;
            2'd2:    lamp = LAMP_YELLOW;
            default: lamp = LAMP_RED;
        endcase
        return lamp;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_sec_tick_gen.sv
// One-second tick generator: a free-running divider that emits a
// single-cycle pulse every TICK_DIV clocks, restarted by reset.
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk_50M,
    input  logic reset_btn,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Divider counts 0..TICK_DIV-1 so the first tick lands TICK_DIV edges after reset
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Sensor-actuated 8-phase sequencer for main road A and side road B.
// Main road rests in green until the side road calls; a green is extended
// while only its own road has traffic, up to MAX_EXT times.
module traffic_phase_scheduler #(
    parameter int TICK_DIV = 50_000_000,
    parameter int A_G_SEC  = 30,
    parameter int B_G_SEC  = 20,
    parameter int L_SEC    = 10,
    parameter int Y_SEC    = 3,
    parameter int AR_SEC   = 2,
    parameter int EXT_SEC  = 5,
    parameter int MAX_EXT  = 4
) (
    input  logic       clk_50M,
    input  logic       reset_btn,
    input  logic       AS1,
    input  logic       AS2,
    input  logic       BS1,
    input  logic       BS2,
    output logic [3:0] a_lamp,
    output logic [3:0] b_lamp,
    output logic [7:0] main_road_countdown,
    output logic [7:0] side_road_countdown,
    output logic [2:0] phase
);

    import traffic_phase_scheduler_pkg::*;

    localparam logic [7:0] A_G_LOAD = 8'(A_G_SEC);
    localparam logic [7:0] B_G_LOAD = 8'(B_G_SEC);
    localparam logic [7:0] L_LOAD   = 8'(L_SEC);
    localparam logic [7:0] Y_LOAD   = 8'(Y_SEC);
    localparam logic [7:0] AR_LOAD  = 8'(AR_SEC);
    localparam logic [7:0] EXT_LOAD = 8'(EXT_SEC);
    localparam logic [7:0] EXT_MAX  = 8'(MAX_EXT);

    phase_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] ext_used, ext_next;
    logic       b_req, b_req_next;
    logic       tick;
    logic       a_dem, b_dem, side_call, can_extend;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk_50M   (clk_50M),
        .reset_btn (reset_btn),
        .tick      (tick)
    );

    assign a_dem      = AS1 | AS2;
    assign b_dem      = BS1 | BS2;
    assign side_call  = b_req | b_dem;
    assign can_extend = (ext_used < EXT_MAX);

    // State register: reset parks the controller in the second all-red clearance
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state    <= ALL_RED2;
            cnt      <= AR_LOAD;
            ext_used <= '0;
            b_req    <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ext_used <= ext_next;
            b_req    <= b_req_next;
        end
    end

    // Next-state logic: count seconds down and take the end-of-phase decision at cnt==1
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ext_next   = ext_used;
        b_req_next = b_req | b_dem;

        if (tick) begin
            if (cnt > 8'd1) begin
                cnt_next = cnt - 8'd1;
            end else begin
                case (state)
                    A_GREEN: begin
                        if (!side_call) begin
                            cnt_next = EXT_LOAD;
                        end else if (a_dem && can_extend) begin
                            cnt_next = EXT_LOAD;
                            ext_next = ext_used + 8'd1;
                        end else begin
                            state_next = A_LEFT;
                            cnt_next   = L_LOAD;
                        end
                    end
                    A_LEFT: begin
                        state_next = A_YELLOW;
                        cnt_next   = Y_LOAD;
                    end
                    A_YELLOW: begin
                        state_next = ALL_RED1;
                        cnt_next   = AR_LOAD;
                    end
                    ALL_RED1: begin
                        state_next = B_GREEN;
                        cnt_next   = B_G_LOAD;
                        ext_next   = '0;
                        b_req_next = 1'b0;
                    end
                    B_GREEN: begin
                        if (b_dem && !a_dem && can_extend) begin
                            cnt_next = EXT_LOAD;
                            ext_next = ext_used + 8'd1;
                        end else begin
                            state_next = B_LEFT;
                            cnt_next   = L_LOAD;
                        end
                    end
                    B_LEFT: begin
                        state_next = B_YELLOW;
                        cnt_next   = Y_LOAD;
                    end
                    B_YELLOW: begin
                        state_next = ALL_RED2;
                        cnt_next   = AR_LOAD;
                    end
                    ALL_RED2: begin
                        state_next = A_GREEN;
                        cnt_next   = A_G_LOAD;
                        ext_next   = '0;
                    end
                    default: begin
                        state_next = ALL_RED2;
                        cnt_next   = AR_LOAD;
                    end
                endcase
            end
        end
    end

    // Output decode: each road shows its lamp only in its own half of the cycle
    always_comb begin
        a_lamp              = LAMP_RED;
        b_lamp              = LAMP_RED;
        main_road_countdown = 8'd0;
        side_road_countdown = 8'd0;
        if (state[2] == 1'b0) begin
            a_lamp = lamp_for_step(state[1:0]);
            if (state[1:0] != 2'd3) begin
                main_road_countdown = cnt;
            end
        end else begin
            b_lamp = lamp_for_step(state[1:0]);
            if (state[1:0] != 2'd3) begin
                side_road_countdown = cnt;
            end
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler with a 4-cycle second.
// A seconds-level model of the intersection is compared against the DUT
// every cycle, and directed scenarios pin key moments with literal values.
module tb_traffic_phase_scheduler;

    localparam int TICK_DIV = 4;

    logic       clk_50M   = 1'b0;
    logic       reset_btn = 1'b0;
    logic       AS1 = 1'b0, AS2 = 1'b0, BS1 = 1'b0, BS2 = 1'b0;
    logic [3:0] a_lamp, b_lamp;
    logic [7:0] main_road_countdown, side_road_countdown;
    logic [2:0] phase;

    int tests_run    = 0;
    int tests_failed = 0;
    int rel_cycles   = 0;

    // Seconds-level model of the intersection
    int dur [8] = '{30, 10, 3, 2, 20, 10, 3, 2};
    int m_phase = 7;
    int m_left  = 2;
    int m_ext   = 0;
    int m_since = 0;
    bit m_breq  = 1'b0;
    bit m_valid = 1'b0;

    traffic_phase_scheduler #(
        .TICK_DIV (TICK_DIV),
        .A_G_SEC  (30),
        .B_G_SEC  (20),
        .L_SEC    (10),
        .Y_SEC    (3),
        .AR_SEC   (2),
        .EXT_SEC  (5),
        .MAX_EXT  (4)
    ) dut (
        .clk_50M             (clk_50M),
        .reset_btn           (reset_btn),
        .AS1                 (AS1),
        .AS2                 (AS2),
        .BS1                 (BS1),
        .BS2                 (BS2),
        .a_lamp              (a_lamp),
        .b_lamp              (b_lamp),
        .main_road_countdown (main_road_countdown),
        .side_road_countdown (side_road_countdown),
        .phase               (phase)
    );

    always #5 clk_50M = ~clk_50M;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void enter_phase(int p);
        m_phase = p;
        m_left  = dur[p];
        if (p == 0 || p == 4) m_ext = 0;
        if (p == 4) m_breq = 1'b0;
    endfunction

    // Model update on each rising edge from the inputs driven at the previous falling edge
    always @(posedge clk_50M) begin : model
        bit a_dem, b_dem, side, tick;
        if (reset_btn) begin
            m_phase    = 7;
            m_left     = 2;
            m_ext      = 0;
            m_breq     = 1'b0;
            m_since    = 0;
            m_valid    = 1'b1;
            rel_cycles = 0;
        end else begin
            rel_cycles++;
            m_since++;
            a_dem  = AS1 | AS2;
            b_dem  = BS1 | BS2;
            side   = m_breq | b_dem;
            tick   = (m_since % TICK_DIV) == 0;
            m_breq = m_breq | b_dem;
            if (tick) begin
                if (m_left > 1) begin
                    m_left--;
                end else if (m_phase == 0) begin
                    if (!side) m_left = 5;
                    else if (a_dem && m_ext < 4) begin m_left = 5; m_ext++; end
                    else enter_phase(1);
                end else if (m_phase == 4) begin
                    if (b_dem && !a_dem && m_ext < 4) begin m_left = 5; m_ext++; end
                    else enter_phase(5);
                end else begin
                    enter_phase((m_phase + 1) % 8);
                end
            end
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk_50M) begin : compare
        logic [3:0] ea, eb;
        logic [7:0] em, es;
        if (m_valid) begin
            ea = 4'b0001; eb = 4'b0001; em = 8'd0; es = 8'd0;
            if (m_phase < 3) begin
                ea = 4'b1000 >> m_phase;
                em = 8'(m_left);
            end else if (m_phase > 3 && m_phase < 7) begin
                eb = 4'b1000 >> (m_phase - 4);
                es = 8'(m_left);
            end
            check_output("model_phase", 32'(phase), 32'(m_phase));
            check_output("model_a_lamp", 32'(a_lamp), 32'(ea));
            check_output("model_b_lamp", 32'(b_lamp), 32'(eb));
            check_output("model_main_cd", 32'(main_road_countdown), 32'(em));
            check_output("model_side_cd", 32'(side_road_countdown), 32'(es));
        end
    end

    task automatic apply_reset(input int n);
        @(negedge clk_50M);
        reset_btn = 1'b1;
        repeat (n) @(negedge clk_50M);
        check_output("reset_phase", 32'(phase), 32'd7);
        check_output("reset_a_lamp", 32'(a_lamp), 32'b0001);
        check_output("reset_b_lamp", 32'(b_lamp), 32'b0001);
        check_output("reset_main_cd", 32'(main_road_countdown), 32'd0);
        check_output("reset_side_cd", 32'(side_road_countdown), 32'd0);
        reset_btn = 1'b0;
    endtask

    task automatic run_to(input int n);
        int guard = 0;
        while (rel_cycles < n && guard < 5000) begin
            @(negedge clk_50M);
            guard++;
        end
        check_output("run_to_cycle", 32'(rel_cycles), 32'(n));
    endtask

    task automatic apply_stimulus();
        // Reset, then two seconds of all-red before main green
        apply_reset(3);
        run_to(7);
        check_output("t1_still_red", 32'(phase), 32'd7);
        run_to(8);
        check_output("t1_phase", 32'(phase), 32'd0);
        check_output("t1_a_lamp", 32'(a_lamp), 32'b1000);
        check_output("t1_main_cd", 32'(main_road_countdown), 32'd30);

        // No traffic: main road rests in green for 200 s
        run_to(128);
        check_output("t2_rest_phase", 32'(phase), 32'd0);
        check_output("t2_rest_cd", 32'(main_road_countdown), 32'd5);
        run_to(808);
        check_output("t2_end_phase", 32'(phase), 32'd0);
        check_output("t2_end_cd", 32'(main_road_countdown), 32'd5);
        check_output("t2_b_lamp", 32'(b_lamp), 32'b0001);

        // One-cycle side call at 10 s into main green
        apply_reset(2);
        run_to(47);
        BS1 = 1'b1;
        run_to(48);
        BS1 = 1'b0;
        run_to(128);
        check_output("t3_a_left", 32'(phase), 32'd1);
        check_output("t3_a_lamp", 32'(a_lamp), 32'b0100);
        check_output("t3_main_cd", 32'(main_road_countdown), 32'd10);
        run_to(188);
        check_output("t3_b_green", 32'(phase), 32'd4);
        check_output("t3_b_lamp", 32'(b_lamp), 32'b1000);
        check_output("t3_side_cd", 32'(side_road_countdown), 32'd20);
        check_output("t3_a_red", 32'(a_lamp), 32'b0001);
        run_to(448);
        check_output("t3_req_cleared", 32'(main_road_countdown), 32'd5);

        // Both roads busy: main gets four extensions, side gets none
        apply_reset(2);
        AS1 = 1'b1;
        BS1 = 1'b1;
        run_to(207);
        check_output("t4_a_last", 32'(main_road_countdown), 32'd1);
        run_to(208);
        check_output("t4_a_left", 32'(phase), 32'd1);
        run_to(268);
        check_output("t4_b_green", 32'(side_road_countdown), 32'd20);
        run_to(348);
        check_output("t4_b_left", 32'(phase), 32'd5);
        check_output("t4_side_cd", 32'(side_road_countdown), 32'd10);
        AS1 = 1'b0;
        BS1 = 1'b0;

        // Side road only: side green extended to 40 s
        apply_reset(2);
        BS2 = 1'b1;
        run_to(188);
        check_output("t5_b_green", 32'(phase), 32'd4);
        run_to(347);
        check_output("t5_b_last", 32'(side_road_countdown), 32'd1);
        run_to(348);
        check_output("t5_b_left", 32'(phase), 32'd5);
        check_output("t5_b_lamp", 32'(b_lamp), 32'b0100);
        check_output("t5_side_cd", 32'(side_road_countdown), 32'd10);

        // Reset pulse in the middle of side green
        apply_reset(1);
        run_to(250);
        check_output("t6_mid_b", 32'(phase), 32'd4);
        apply_reset(1);
        BS2 = 1'b0;
        run_to(7);
        check_output("t6_still_red", 32'(phase), 32'd7);
        run_to(8);
        check_output("t6_a_green", 32'(phase), 32'd0);
        check_output("t6_main_cd", 32'(main_road_countdown), 32'd30);
    endtask

    initial begin
        apply_stimulus();
        @(negedge clk_50M);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
